// File: rtl/fifo_push_arbiter_if.sv
// Handshake bundle between the requesters/downstream FIFO manager (master)
// and the round-robin push arbiter (slave).
interface fifo_push_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 48,
  parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic              en;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_record;
  logic [NREQ-1:0]   ack;
  logic              fifo_full;
  logic              push_to_fifo;
  logic [W-1:0]      push_record;
  logic [15:0]       push_cnt;
  logic [15:0]       stall_cnt;
  logic [LGW-1:0]    last_grant;

  modport master (
    output en, req, req_record, fifo_full,
    input  ack, push_to_fifo, push_record, push_cnt, stall_cnt, last_grant
  );

  modport slave (
    input  en, req, req_record, fifo_full,
    output ack, push_to_fifo, push_record, push_cnt, stall_cnt, last_grant
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter feeding a single registered push stage into a FIFO.
// A new record is granted whenever the stage is empty or drains on this edge.
module fifo_push_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 48,
  parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input logic               clk,
  input logic               rst_b,
  fifo_push_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           push_q, push_d;
  logic [W-1:0]   rec_q, rec_d;
  logic [15:0]    pcnt_q, pcnt_d;
  logic [15:0]    scnt_q, scnt_d;
  logic [LGW-1:0] last_q, last_d;

  logic           accept;
  logic           stalled;
  logic           stage_free;
  logic           found;
  logic [LGW-1:0] grant_idx;
  logic [W-1:0]   grant_rec;
  logic [NREQ-1:0] ack_c;
  int             cand;

  // NOTE: every variable gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    push_d     = push_q;
    rec_d      = rec_q;
    pcnt_d     = pcnt_q;
    scnt_d     = scnt_q;
    last_d     = last_q;
    ack_c      = '0;
    found      = 1'b0;
    grant_idx  = '0;
    grant_rec  = '0;
    cand       = 0;

    accept     = push_q && !bus.fifo_full;
    stalled    = push_q && bus.fifo_full;
    stage_free = !push_q || accept;

    // Search starts one past the previous winner so every requester is served in turn.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!found && bus.req[cand]) begin
        found     = 1'b1;
        grant_idx = LGW'(cand);
        grant_rec = bus.req_record[cand*W +: W];
      end
    end

    // Reset is folded in so no requester sees an ack while the block is held.
    if (rst_b && bus.en && stage_free && found) begin
      ack_c[grant_idx] = 1'b1;
    end

    if (accept) begin
      pcnt_d = pcnt_q + 16'd1;
    end
    if (stalled && (scnt_q != 16'hFFFF)) begin
      scnt_d = scnt_q + 16'd1;
    end

    if (|ack_c) begin
      rec_d   = grant_rec;
      push_d  = 1'b1;
      last_d  = grant_idx;
      state_d = SEND;
    end else if (accept) begin
      push_d  = 1'b0;
      state_d = IDLE;
    end else if (stalled) begin
      state_d = STALL;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the staged record is a single datapath register, so it is cleared on
  // reset along with control; a discarded record must never reappear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      rec_q   <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
      last_q  <= LGW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      rec_q   <= rec_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
      last_q  <= last_d;
    end
  end

  assign bus.ack          = ack_c;
  assign bus.push_to_fifo = push_q;
  assign bus.push_record  = rec_q;
  assign bus.push_cnt     = pcnt_q;
  assign bus.stall_cnt    = scnt_q;
  assign bus.last_grant   = last_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scenario bench for fifo_push_arbiter: directed cases plus a randomized run,
// all compared against a stage/round-robin reference model.
module tb_fifo_push_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 48;

  logic clk;
  logic rst_b;

  fifo_push_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  fifo_push_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one stage slot, last winner, two counters.
  bit          m_valid;
  logic [W-1:0] m_rec;
  int          m_last;
  logic [15:0] m_pcnt;
  logic [15:0] m_scnt;
  int          grants[$];

  task automatic model_reset();
    m_valid = 0;
    m_rec   = '0;
    m_last  = NREQ - 1;
    m_pcnt  = '0;
    m_scnt  = '0;
    grants.delete();
  endtask

  function automatic logic [NREQ-1:0] model_ack();
    logic [NREQ-1:0] a;
    int i;
    a = '0;
    if (rst_b && bus.en && (!m_valid || !bus.fifo_full)) begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_last + k) % NREQ;
        if (a == '0 && bus.req[i]) a[i] = 1'b1;
      end
    end
    return a;
  endfunction

  task automatic set_rec(input int i);
    bus.req_record[i*W +: W] = {16'($urandom()), 32'($urandom())};
  endtask

  // Advance one edge, updating the model from the inputs that were held across it.
  task automatic tick();
    logic [NREQ-1:0] a;
    bit acc;
    a = model_ack();
    @(posedge clk);
    acc = m_valid && !bus.fifo_full;
    if (m_valid && bus.fifo_full && m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
    if (acc) m_pcnt = m_pcnt + 16'd1;
    if (a != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (a[i]) begin
          m_rec  = bus.req_record[i*W +: W];
          m_last = i;
        end
      end
      m_valid = 1;
      grants.push_back(m_last);
    end else if (acc) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.en = 1'b1;
    #3;
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    bus.req = 4'b0001;
    set_rec(0);
    #1;
    tick();
    #2;
    rst_b = 1'b0;
    bus.req = 4'b1111;
    #1;
    n_checks++; if (bus.push_to_fifo !== 1'b0) $display("FAIL reset_push got %b exp 0", bus.push_to_fifo); else n_pass++;
    n_checks++; if (bus.push_cnt !== 16'd0) $display("FAIL reset_push_cnt got %0h exp 0", bus.push_cnt); else n_pass++;
    n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got %0h exp 0", bus.stall_cnt); else n_pass++;
    n_checks++; if (bus.last_grant !== 2'd3) $display("FAIL reset_last_grant got %0d exp 3", bus.last_grant); else n_pass++;
    n_checks++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", bus.ack); else n_pass++;
    n_checks++; if (bus.push_record !== '0) $display("FAIL reset_record got %h exp 0", bus.push_record); else n_pass++;
    model_reset();
    bus.req = '0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bus.en = 1'b1;
    bus.fifo_full = 1'b0;
    bus.req = 4'b0010;
    bus.req_record[1*W +: W] = 48'h0000_0000_00AA;
    #1;
    n_checks++; if (bus.ack !== 4'b0010) $display("FAIL single_ack got %b exp 0010", bus.ack); else n_pass++;
    tick();
    bus.req = '0;
    #1;
    n_checks++; if (bus.push_to_fifo !== 1'b1) $display("FAIL single_push got %b exp 1", bus.push_to_fifo); else n_pass++;
    n_checks++; if (bus.push_record !== 48'hAA) $display("FAIL single_record got %h exp aa", bus.push_record); else n_pass++;
    tick();
    n_checks++; if (bus.push_to_fifo !== 1'b0) $display("FAIL single_idle got %b exp 0", bus.push_to_fifo); else n_pass++;
    n_checks++; if (bus.push_cnt !== 16'd1) $display("FAIL single_push_cnt got %0d exp 1", bus.push_cnt); else n_pass++;
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_rec;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_rec(i);
    bus.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++; if (bus.ack !== 4'(1 << (c % 4))) $display("FAIL contention_ack c=%0d got %b exp %b", c, bus.ack, 4'(1 << (c % 4))); else n_pass++;
      exp_rec = bus.req_record[(c % 4)*W +: W];
      tick();
      n_checks++; if (bus.push_record !== exp_rec || bus.push_to_fifo !== 1'b1) $display("FAIL contention_stage c=%0d got %b/%h exp 1/%h", c, bus.push_to_fifo, bus.push_record, exp_rec); else n_pass++;
      set_rec(c % 4);
    end
    bus.req = '0;
    #1;
    tick();
    n_checks++; if (bus.push_cnt !== 16'd8) $display("FAIL contention_push_cnt got %0d exp 8", bus.push_cnt); else n_pass++;
    n_checks++; if (bus.push_to_fifo !== 1'b0) $display("FAIL contention_idle got %b exp 0", bus.push_to_fifo); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    logic [15:0] pc0;
    bus.req = 4'b0100;
    set_rec(2);
    #1;
    tick();
    held = bus.req_record[2*W +: W];
    pc0 = bus.push_cnt;
    bus.req = 4'b1001;
    set_rec(0);
    set_rec(3);
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (bus.ack !== 4'b0000) $display("FAIL bp_ack c=%0d got %b exp 0000", c, bus.ack); else n_pass++;
      tick();
      n_checks++; if (bus.push_record !== held || bus.push_to_fifo !== 1'b1) $display("FAIL bp_hold c=%0d got %b/%h exp 1/%h", c, bus.push_to_fifo, bus.push_record, held); else n_pass++;
    end
    n_checks++; if (bus.stall_cnt !== 16'd3) $display("FAIL bp_stall_cnt got %0d exp 3", bus.stall_cnt); else n_pass++;
    bus.fifo_full = 1'b0;
    #1;
    n_checks++; if (bus.ack !== 4'b1000) $display("FAIL bp_release_ack got %b exp 1000", bus.ack); else n_pass++;
    tick();
    n_checks++; if (bus.push_cnt !== pc0 + 16'd1) $display("FAIL bp_release_cnt got %0d exp %0d", bus.push_cnt, pc0 + 16'd1); else n_pass++;
    n_checks++; if (bus.push_record !== bus.req_record[3*W +: W]) $display("FAIL bp_release_rec got %h exp %h", bus.push_record, bus.req_record[3*W +: W]); else n_pass++;
  endtask

  task automatic test_enable();
    bus.en = 1'b0;
    bus.req = 4'b0100;
    set_rec(2);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (bus.ack !== 4'b0000) $display("FAIL en_ack c=%0d got %b exp 0000", c, bus.ack); else n_pass++;
      tick();
      n_checks++; if (bus.push_to_fifo !== 1'b0) $display("FAIL en_drain c=%0d got %b exp 0", c, bus.push_to_fifo); else n_pass++;
    end
    bus.en = 1'b1;
    #1;
    n_checks++; if (bus.ack !== 4'b0100) $display("FAIL en_raise_ack got %b exp 0100", bus.ack); else n_pass++;
    tick();
    bus.req = '0;
  endtask

  task automatic test_reset_stall();
    bus.fifo_full = 1'b1;
    #1;
    tick();
    n_checks++; if (bus.push_to_fifo !== 1'b1) $display("FAIL rs_stalled got %b exp 1", bus.push_to_fifo); else n_pass++;
    #2;
    rst_b = 1'b0;
    #1;
    n_checks++; if (bus.push_to_fifo !== 1'b0) $display("FAIL rs_push got %b exp 0", bus.push_to_fifo); else n_pass++;
    model_reset();
    bus.req = 4'b1001;
    set_rec(0);
    set_rec(3);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    n_checks++; if (bus.ack !== 4'b0001) $display("FAIL rs_first_ack got %b exp 0001", bus.ack); else n_pass++;
    bus.fifo_full = 1'b0;
    tick();
    n_checks++; if (bus.push_record !== bus.req_record[0 +: W]) $display("FAIL rs_record got %h exp %h", bus.push_record, bus.req_record[0 +: W]); else n_pass++;
    bus.req = '0;
    #1;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.req = 4'($urandom());
      bus.en = ($urandom_range(0, 7) != 0);
      bus.fifo_full = ($urandom_range(0, 9) < 3);
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) set_rec(i);
      #1;
      n_checks++; if (bus.ack !== model_ack()) begin errs++; $display("FAIL rand_ack c=%0d got %b exp %b", c, bus.ack, model_ack()); end else n_pass++;
      tick();
      n_checks++;
      if (bus.push_to_fifo !== m_valid || bus.push_record !== m_rec || bus.push_cnt !== m_pcnt ||
          bus.stall_cnt !== m_scnt || bus.last_grant !== 2'(m_last)) begin
        errs++;
        $display("FAIL rand_state c=%0d got %b/%h/%0d/%0d/%0d exp %b/%h/%0d/%0d/%0d", c,
                 bus.push_to_fifo, bus.push_record, bus.push_cnt, bus.stall_cnt, bus.last_grant,
                 m_valid, m_rec, m_pcnt, m_scnt, m_last);
      end else n_pass++;
      if (errs > 10) break;
    end
    bus.req = '0;
    bus.en = 1'b1;
    bus.fifo_full = 1'b0;
  endtask

  task automatic test_stall_saturate();
    do_reset();
    bus.req = 4'b0001;
    set_rec(0);
    #1;
    tick();
    bus.req = '0;
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 65540; c++) tick();
    n_checks++; if (bus.stall_cnt !== 16'hFFFF) $display("FAIL sat_stall_cnt got %h exp ffff", bus.stall_cnt); else n_pass++;
    n_checks++; if (bus.push_to_fifo !== 1'b1 || bus.push_cnt !== 16'd0) $display("FAIL sat_hold got %b/%0d exp 1/0", bus.push_to_fifo, bus.push_cnt); else n_pass++;
    bus.fifo_full = 1'b0;
    #1;
    tick();
    n_checks++; if (bus.push_cnt !== 16'd1 || bus.push_to_fifo !== 1'b0) $display("FAIL sat_drain got %0d/%b exp 1/0", bus.push_cnt, bus.push_to_fifo); else n_pass++;
  endtask

  initial begin
    rst_b = 1'b0;
    bus.en = 1'b0;
    bus.req = '0;
    bus.req_record = '0;
    bus.fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_enable();
    test_reset_stall();
    test_random();
    test_stall_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the FIFO push port.
REQ-002 Parameter W, default 48, record width in bits (6*8).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  grant enable; low blocks new grants only.
REQ-006 req  input  NREQ  per-requester record-valid.
REQ-007 req_record  input  NREQ*W  records, requester i at bits [i*W+W-1 : i*W].
REQ-008 ack  output  NREQ  combinational one-hot grant; record i captured at the end of this cycle.
REQ-009 fifo_full  input  1  FIFO full flag from the downstream FIFO manager.
REQ-010 push_to_fifo  output  1  registered; staged record valid.
REQ-011 push_record  output  W  registered; staged record.
REQ-012 push_cnt  output  16  accepted-push counter, wraps.
REQ-013 stall_cnt  output  16  cycles with push_to_fifo&&fifo_full, saturates at 0xFFFF.
REQ-014 last_grant  output  2  index of the most recent grant.

Function
REQ-015 The block SHALL hold one output stage; a push is accepted at a posedge where push_to_fifo && !fifo_full.
REQ-016 Stage "free" SHALL mean: stage empty, or the stage record is accepted at this edge.
REQ-017 ack[i] SHALL assert only when the stage is free, en=1, req[i]=1, and i is first in round-robin order last_grant+1, +2, ..., last_grant (mod NREQ).
REQ-018 At most one ack bit SHALL be high per cycle; ack SHALL be 0 when no request is pending, when en=0, or when the stage is not free.
REQ-019 On an ack[i] edge: push_record <= req_record[i]; push_to_fifo <= 1; last_grant <= i; the requester may advance its record on that same edge.
REQ-020 Latency: req[i] asserted in IDLE in cycle n -> ack[i] in cycle n -> push_to_fifo=1 with the record in cycle n+1.
REQ-021 Throughput: one accepted push per cycle while requests are pending and fifo_full=0.
REQ-022 The FSM SHALL use the states IDLE (stage empty), SEND (stage valid, last edge fifo_full=0) and STALL (stage valid, fifo_full seen).
REQ-023 IDLE: a grant -> SEND; otherwise stay IDLE.
REQ-024 SEND/STALL with fifo_full=1: hold push_record and push_to_fifo, no ack, -> STALL.
REQ-025 SEND/STALL with fifo_full=0: accept; a grant in the same cycle -> SEND with the new record; no grant -> IDLE with push_to_fifo <= 0.
REQ-026 push_record SHALL remain stable while push_to_fifo=1 and the record is not accepted.
REQ-027 push_cnt SHALL increment by 1 per accepted push and wrap 0xFFFF -> 0x0000.
REQ-028 stall_cnt SHALL increment on each edge with push_to_fifo && fifo_full and hold at 0xFFFF.
REQ-029 With en=0, a staged record SHALL still drain normally; en only gates REQ-017.
REQ-030 A requester dropping req without an ack SHALL lose nothing; no record is captured without ack.

Reset
REQ-031 rst_b=0 SHALL immediately (asynchronously) force: state IDLE, push_to_fifo=0, push_record=0, push_cnt=0, stall_cnt=0, last_grant=NREQ-1.
REQ-032 ack SHALL be 0 while rst_b=0.
REQ-033 Reset mid-operation (SEND/STALL) SHALL discard the staged record without a push.
REQ-034 After rst_b rises, requester 0 SHALL have first priority.

Verification
REQ-035 Reset: assert rst_b=0 mid-cycle -> push_to_fifo=0, push_cnt=0, stall_cnt=0 and last_grant=3 before the next posedge.
REQ-036 Single request: req=0010, req_record[1]=48'h0000_0000_00AA, fifo_full=0 -> ack=0010 in cycle 0; push_to_fifo=1 and push_record=48'hAA in cycle 1; IDLE with push_to_fifo=0 in cycle 2; push_cnt=1.
REQ-037 Full contention: req=1111 held for 8 cycles, fifo_full=0 -> grants in order 0,1,2,3,0,1,2,3, one push per cycle, push_cnt=8.
REQ-038 Backpressure: fifo_full=1 for 3 cycles while in SEND -> push_record unchanged, ack=0, stall_cnt=3; on fifo_full=0 the push is accepted and the next pending requester is acked in the same cycle.
REQ-039 Enable gate: en=0, req=0100, stage holding a record -> the record drains, ack stays 0, state IDLE; raising en -> ack=0100 in that cycle.
REQ-040 Reset in STALL: rst_b=0 while fifo_full=1 and push_to_fifo=1 -> push_to_fifo=0 immediately; after release with req=1001 -> ack=0001 first.
